// File: rtl/bcd_converter_if.sv
// rtl/bcd_converter_if.sv - start/busy/done handshake and result bus of the binary-to-BCD converter
//
// Signals:
//   start, value[WIDTH], signed_mode : request side, driven by the master
//   busy, done                       : conversion status, driven by the converter
//   bcd[4*DIGITS], negative, blank[DIGITS] : latched decimal result
// Modports: master (requester), slave (converter).

interface bcd_converter_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      value;
  logic                  signed_mode;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  negative;
  logic [DIGITS-1:0]     blank;

  modport master (
    output start, value, signed_mode,
    input  busy, done, bcd, negative, blank
  );

  modport slave (
    input  start, value, signed_mode,
    output busy, done, bcd, negative, blank
  );
endinterface

// File: rtl/bcd_converter.sv
// rtl/bcd_converter.sv - sequential double-dabble binary-to-BCD converter with sign and leading-zero mask
//
// Ports:
//   sys_clk : system clock, all state changes on its rising edge
//   rst     : synchronous active-high reset
//   bus     : bcd_converter_if.slave (start/value/signed_mode in; busy/done/bcd/negative/blank out)
// One shift iteration per cycle; done pulses WIDTH edges after the accepting edge.

module bcd_converter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic           sys_clk,
  input  logic           rst,
  bcd_converter_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int BW = 4 * DIGITS;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  mag_q;
  logic [BW-1:0]     scratch_q;
  logic [CW-1:0]     cnt_q;
  logic              sign_q;

  logic              busy_q;
  logic              done_q;
  logic [BW-1:0]     bcd_q;
  logic              negative_q;
  logic [DIGITS-1:0] blank_q;

  logic [WIDTH-1:0]  start_mag;
  logic              start_neg;
  logic [BW-1:0]     adjusted;
  logic [BW-1:0]     next_scratch;
  logic [DIGITS-1:0] blank_next;
  logic              all_zero;

  // Negative values are converted through their magnitude; 0x80 in signed
  // mode wraps to 0x80 again, which reads as 128 unsigned.
  always_comb begin
    start_neg = bus.signed_mode & bus.value[WIDTH-1];
    start_mag = start_neg ? (~bus.value + 1'b1) : bus.value;
  end

  // Add-3 correction before the shift so any digit >= 5 carries correctly
  // into the next digit when doubled.
  always_comb begin
    adjusted = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5)
        adjusted[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      else
        adjusted[4*i +: 4] = scratch_q[4*i +: 4];
    end
    next_scratch = {adjusted[BW-2:0], mag_q[WIDTH-1]};
  end

  // Leading-zero mask of the digits produced by the final iteration. Digit 0
  // is never blanked so a zero result still shows a single "0".
  always_comb begin
    blank_next = '0;
    all_zero   = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero      = all_zero & (next_scratch[4*i +: 4] == 4'd0);
      blank_next[i] = all_zero;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mag_q      <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      sign_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      negative_q <= 1'b0;
      blank_q    <= {{(DIGITS-1){1'b1}}, 1'b0};
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            mag_q     <= start_mag;
            sign_q    <= start_neg;
            scratch_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch_q <= next_scratch;
          mag_q     <= {mag_q[WIDTH-2:0], 1'b0};
          cnt_q     <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            bcd_q      <= next_scratch;
            negative_q <= sign_q;
            blank_q    <= blank_next;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bcd      = bcd_q;
  assign bus.negative = negative_q;
  assign bus.blank    = blank_q;

endmodule

// File: doc/bcd_converter.md
Name: bcd_converter

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble) for the output stage.
- Takes the latched 8-bit output value and produces decimal digits, a sign flag and a leading-zero blank mask.
- The seven-segment driver consumes these outputs, so the display can show decimal (unsigned 0..255 or signed -128..127) instead of hex.
- Runs on sys_clk, one iteration per cycle, with a start/busy/done handshake.

Parameters:
- WIDTH, 8, binary input width in bits; also the number of shift iterations.
- DIGITS, 3, number of BCD digits produced. Must satisfy 10^DIGITS > 2^WIDTH - 1; the bench checks this at elaboration.

Ports:
- sys_clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a conversion of value; honoured only in IDLE.
- value  input  WIDTH  binary value to convert; sampled only on the accepting edge.
- signed_mode  input  1  1 = treat value as two's complement; sampled with value.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; result outputs are valid and newly updated.
- bcd  output  4*DIGITS  digit i at bits [4i+3:4i]; i=0 is ones.
- negative  output  1  result sign; 1 only in signed_mode with value[WIDTH-1]=1.
- blank  output  DIGITS  bit i high = digit i is a leading zero. Bit 0 is always 0.

Behaviour:
- Reset (synchronous; takes priority over everything, including mid-conversion):
  - state returns to IDLE.
  - busy=0, done=0, bcd=0, negative=0.
  - blank = all ones except bit 0.
  - Any in-flight conversion is discarded; no done is produced for it.
- States: IDLE, SHIFT.
- IDLE:
  - On an edge with start=1, capture the magnitude into the shift register.
    - If signed_mode and value[WIDTH-1], magnitude = (~value + 1) truncated to WIDTH bits, so 0x80 gives 128.
    - Otherwise magnitude = value.
  - On the same edge: capture the sign, clear the BCD scratch, iteration counter = 0, busy=1, go to SHIFT.
  - Any other IDLE edge: hold.
- SHIFT:
  - Each edge, every scratch digit >= 5 gets +3 (combinational).
  - Then {scratch, magnitude} shifts left by 1, and the counter increments.
  - On the edge performing iteration WIDTH (counter == WIDTH-1):
    - Register the final digits into bcd, the sign into negative, and compute blank.
    - Set busy=0, done=1, return to IDLE.
- Latency:
  - Start accepted at edge k; busy high in cycles k+1 .. k+WIDTH.
  - Outputs and done update at edge k+WIDTH (8 for the default).
  - done is high for exactly one cycle, cleared at edge k+WIDTH+1.
- Back-to-back: start=1 during the done cycle (state is IDLE) is accepted. done then falls and busy rises on the same edge.
- start while busy: ignored. No queueing; value and signed_mode are not resampled.
- Between conversions, bcd, negative and blank hold their last values.
- blank: scanning from digit DIGITS-1 downward, a digit is blanked while it and all higher digits are zero. Digit 0 is never blanked, so value 0 gives blank=3'b110.
- negative with magnitude 0 cannot occur: signed 0 has value[WIDTH-1]=0.
- Scratch digits never exceed 9 after an iteration; no carry out of digit DIGITS-1 given the parameter constraint.

Test Plan:
- Reset then idle -> busy=0, done=0, bcd=0x000, negative=0, blank=3'b110. Holds with start=0 for 20 cycles.
- value=0xFF, signed_mode=0, start pulse -> busy high 8 cycles; done one cycle, 8 edges after accept; bcd=0x255, negative=0, blank=3'b000.
- signed_mode=1: 0x80 -> bcd=0x128, negative=1; 0xFF -> bcd=0x001, negative=1, blank=3'b110; 0x7F -> bcd=0x127, negative=0.
- Unsigned 0x00 -> bcd=0x000, blank=3'b110. Unsigned 0x0A -> bcd=0x010, blank=3'b100.
- start held high continuously with value changing each cycle -> conversions back-to-back every 9 cycles. Each result matches the value present on its accepting edge; start during busy has no effect.
- Assert rst at the 4th SHIFT cycle of a 0xC8 conversion -> next edge all outputs at reset values, no done pulse. A following conversion of 0x2A gives bcd=0x042 correctly.
